// File: rtl/addr8u_result_checker.sv
// Two-stage checker behind the 8-bit unsigned adder: captures A/B/O, recomputes A+B,
// forwards O with an error flag over valid/ready and keeps fault-campaign statistics.
module addr8u_result_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH:0]   in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_err,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic [WIDTH:0]   first_sum
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Full-width compare so a wrong carry-out bit is caught as well.
    function automatic logic sum_mismatch(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH:0]   sum
    );
        logic [WIDTH:0] golden;
        golden = {1'b0, a} + {1'b0, b};
        return (sum != golden);
    endfunction

    logic             s1_v_r;
    logic             s2_v_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [WIDTH:0]   s1_sum_r;
    logic [WIDTH:0]   out_sum_r;
    logic             out_err_r;
    logic [CNT_W-1:0] err_count_r;
    logic             err_sticky_r;
    logic [WIDTH-1:0] first_a_r;
    logic [WIDTH-1:0] first_b_r;
    logic [WIDTH:0]   first_sum_r;

    logic             in_ready_s;
    logic             in_fire_s;
    logic             s1_adv_s;
    logic             s1_err_s;
    logic             commit_s;

    // Handshake decode; in_ready depends only on stage state and out_ready.
    always_comb begin
        in_ready_s = !s1_v_r || !s2_v_r || out_ready;
        in_fire_s  = in_valid && in_ready_s;
        s1_adv_s   = s1_v_r && (!s2_v_r || out_ready);
        s1_err_s   = sum_mismatch(s1_a_r, s1_b_r, s1_sum_r);
        commit_s   = s1_adv_s && s1_err_s;
    end

    // S1 capture stage: a new beat may load in the same cycle the old one advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r   <= 1'b0;
            s1_a_r   <= {WIDTH{1'b0}};
            s1_b_r   <= {WIDTH{1'b0}};
            s1_sum_r <= {(WIDTH+1){1'b0}};
        end else if (in_fire_s) begin
            s1_v_r   <= 1'b1;
            s1_a_r   <= in_a;
            s1_b_r   <= in_b;
            s1_sum_r <= in_sum;
        end else if (s1_adv_s) begin
            s1_v_r   <= 1'b0;
        end
    end

    // S2 compare stage: payload only changes on a load, so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_r    <= 1'b0;
            out_sum_r <= {(WIDTH+1){1'b0}};
            out_err_r <= 1'b0;
        end else if (s1_adv_s) begin
            s2_v_r    <= 1'b1;
            out_sum_r <= s1_sum_r;
            out_err_r <= s1_err_s;
        end else if (out_ready) begin
            s2_v_r    <= 1'b0;
        end
    end

    // Statistics commit when an erroneous beat enters S2; clr_stats wins over a commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r  <= {CNT_W{1'b0}};
            err_sticky_r <= 1'b0;
            first_a_r    <= {WIDTH{1'b0}};
            first_b_r    <= {WIDTH{1'b0}};
            first_sum_r  <= {(WIDTH+1){1'b0}};
        end else if (clr_stats) begin
            err_count_r  <= {CNT_W{1'b0}};
            err_sticky_r <= 1'b0;
            first_a_r    <= {WIDTH{1'b0}};
            first_b_r    <= {WIDTH{1'b0}};
            first_sum_r  <= {(WIDTH+1){1'b0}};
        end else if (commit_s) begin
            if (err_count_r != CNT_MAX) begin
                err_count_r <= err_count_r + CNT_ONE;
            end
            if (!err_sticky_r) begin
                err_sticky_r <= 1'b1;
                first_a_r    <= s1_a_r;
                first_b_r    <= s1_b_r;
                first_sum_r  <= s1_sum_r;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = s2_v_r;
    assign out_sum    = out_sum_r;
    assign out_err    = out_err_r;
    assign err_count  = err_count_r;
    assign err_sticky = err_sticky_r;
    assign first_a    = first_a_r;
    assign first_b    = first_b_r;
    assign first_sum  = first_sum_r;

endmodule

// File: tb/tb_addr8u_result_checker.sv
// Randomised self-checking bench for addr8u_result_checker; an in-order scoreboard
// models the result stream and a rule-level model tracks the statistics.
module tb_addr8u_result_checker;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = 8'd0;
    logic [WIDTH-1:0] in_b = 8'd0;
    logic [WIDTH:0]   in_sum = 9'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH:0]   out_sum;
    logic             out_err;
    logic             clr_stats = 1'b0;
    logic [CNT_W-1:0] err_count;
    logic             err_sticky;
    logic [WIDTH-1:0] first_a;
    logic [WIDTH-1:0] first_b;
    logic [WIDTH:0]   first_sum;

    int npass = 0;
    int ncheck = 0;
    int n_out = 0;

    logic [9:0] exp_q[$];
    logic [9:0] exp_item;
    int         m_cnt = 0;
    bit         m_sticky = 1'b0;
    logic [7:0] m_a = 8'd0;
    logic [7:0] m_b = 8'd0;
    logic [8:0] m_sum = 9'd0;

    addr8u_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_err(out_err),
        .clr_stats(clr_stats), .err_count(err_count), .err_sticky(err_sticky),
        .first_a(first_a), .first_b(first_b), .first_sum(first_sum)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted beat must emerge once, in order, with err = (O != A+B).
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                ncheck++;
                if (exp_q.size() == 0) begin
                    $display("FAIL out_beat: unexpected beat err=%0b sum=%h, none expected", out_err, out_sum);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({out_err, out_sum} !== exp_item)
                        $display("FAIL out_beat: got err=%0b sum=%h, want err=%0b sum=%h",
                                 out_err, out_sum, exp_item[9], exp_item[8:0]);
                    else
                        npass++;
                end
            end
            if (in_valid && in_ready) begin
                if (int'(in_a) + int'(in_b) != int'(in_sum)) begin
                    exp_q.push_back({1'b1, in_sum});
                    if (m_cnt < CNT_MAX) m_cnt++;
                    if (!m_sticky) begin
                        m_sticky = 1'b1;
                        m_a = in_a;
                        m_b = in_b;
                        m_sum = in_sum;
                    end
                end else begin
                    exp_q.push_back({1'b0, in_sum});
                end
            end
        end
    end

    function automatic logic [8:0] make_sum(input logic [7:0] a, input logic [7:0] b, input bit faulty);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (faulty) s = s ^ (9'd1 << $urandom_range(0, 8));
        return s;
    endfunction

    task automatic model_clear();
        m_cnt = 0;
        m_sticky = 1'b0;
        m_a = 8'd0;
        m_b = 8'd0;
        m_sum = 9'd0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        ncheck++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid); else npass++;
        ncheck++; if ({out_err, out_sum} !== 10'd0) $display("FAIL reset_out: got %h want 0", {out_err, out_sum}); else npass++;
        ncheck++; if ({err_sticky, err_count} !== 5'd0) $display("FAIL reset_stats: got %h want 0", {err_sticky, err_count}); else npass++;
        ncheck++; if ({first_a, first_b, first_sum} !== 25'd0) $display("FAIL reset_first: got %h want 0", {first_a, first_b, first_sum}); else npass++;
        rst_n = 1'b1;
        #1;
        ncheck++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", in_ready); else npass++;
    endtask

    task automatic test_golden();
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd200; in_b = 8'd100; in_sum = 9'h12C;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ncheck++; if (out_valid !== 1'b0) $display("FAIL golden_early: got %0b want 0", out_valid); else npass++;
        @(posedge clk); #1;
        ncheck++; if (out_valid !== 1'b1) $display("FAIL golden_latency: got %0b want 1", out_valid); else npass++;
        ncheck++; if ({out_err, out_sum} !== {1'b0, 9'h12C}) $display("FAIL golden_out: got %h want %h", {out_err, out_sum}, {1'b0, 9'h12C}); else npass++;
        repeat (3) @(posedge clk); #1;
        ncheck++; if (err_count !== 4'(m_cnt)) $display("FAIL golden_count: got %0d want %0d", err_count, m_cnt); else npass++;
    endtask

    task automatic test_fault();
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = 8'd200; in_b = 8'd100; in_sum = 9'h12D;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        ncheck++; if (err_count !== 4'(m_cnt)) $display("FAIL fault_count: got %0d want %0d", err_count, m_cnt); else npass++;
        ncheck++; if (err_sticky !== m_sticky) $display("FAIL fault_sticky: got %0b want %0b", err_sticky, m_sticky); else npass++;
        ncheck++; if ({first_a, first_b, first_sum} !== {m_a, m_b, m_sum}) $display("FAIL fault_first: got %h want %h", {first_a, first_b, first_sum}, {m_a, m_b, m_sum}); else npass++;
        in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1; in_sum = 9'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        ncheck++; if (err_count !== 4'(m_cnt)) $display("FAIL fault2_count: got %0d want %0d", err_count, m_cnt); else npass++;
        ncheck++; if ({first_a, first_b, first_sum} !== {m_a, m_b, m_sum}) $display("FAIL fault2_first: got %h want %h", {first_a, first_b, first_sum}, {m_a, m_b, m_sum}); else npass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] bp_a[5];
        logic [7:0] bp_b[5];
        logic [8:0] bp_s[5];
        int acc = 0;
        int out_start;
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = 8'($urandom);
            bp_b[i] = 8'($urandom);
            bp_s[i] = make_sum(bp_a[i], bp_b[i], $urandom_range(0, 1) == 1);
        end
        out_start = n_out;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            in_valid = 1'b1; in_a = bp_a[acc]; in_b = bp_b[acc]; in_sum = bp_s[acc];
            #1;
            if (in_ready) acc++;
            @(posedge clk); #1;
            if (cyc >= 2) begin
                ncheck++; if (out_sum !== bp_s[0]) $display("FAIL bp_stable: got %h want %h", out_sum, bp_s[0]); else npass++;
            end
        end
        in_valid = 1'b0;
        ncheck++; if (acc != 2) $display("FAIL bp_accepted: got %0d want 2", acc); else npass++;
        ncheck++; if (in_ready !== 1'b0) $display("FAIL bp_ready: got %0b want 0", in_ready); else npass++;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && acc < 5; cyc++) begin
            in_valid = 1'b1; in_a = bp_a[acc]; in_b = bp_b[acc]; in_sum = bp_s[acc];
            #1;
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        ncheck++; if (n_out - out_start != 5) $display("FAIL bp_count: got %0d beats want 5", n_out - out_start); else npass++;
        ncheck++; if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d pending want 0", exp_q.size()); else npass++;
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            a = 8'($urandom);
            b = 8'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a = a; in_b = b;
            in_sum    = make_sum(a, b, $urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        ncheck++; if (exp_q.size() != 0) $display("FAIL rand_drain: got %0d pending want 0", exp_q.size()); else npass++;
        ncheck++; if ({err_sticky, err_count} !== {m_sticky, 4'(m_cnt)}) $display("FAIL rand_stats: got %h want %h", {err_sticky, err_count}, {m_sticky, 4'(m_cnt)}); else npass++;
        ncheck++; if ({first_a, first_b, first_sum} !== {m_a, m_b, m_sum}) $display("FAIL rand_first: got %h want %h", {first_a, first_b, first_sum}, {m_a, m_b, m_sum}); else npass++;
    endtask

    task automatic test_saturation();
        logic [7:0] a;
        logic [7:0] b;
        @(posedge clk); #1;
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        model_clear();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            in_valid = 1'b1; in_a = a; in_b = b; in_sum = make_sum(a, b, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        ncheck++; if (err_count !== 4'(m_cnt)) $display("FAIL sat_count: got %0d want %0d", err_count, m_cnt); else npass++;
        ncheck++; if ({first_a, first_b, first_sum} !== {m_a, m_b, m_sum}) $display("FAIL sat_first: got %h want %h", {first_a, first_b, first_sum}, {m_a, m_b, m_sum}); else npass++;
    endtask

    task automatic test_clr_coincident();
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd17; in_b = 8'd40; in_sum = 9'd58;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        model_clear();
        ncheck++; if ({out_valid, out_err} !== 2'b11) $display("FAIL clr_out: got valid/err %b want 11", {out_valid, out_err}); else npass++;
        ncheck++; if ({err_sticky, err_count} !== 5'd0) $display("FAIL clr_stats: got %h want 0", {err_sticky, err_count}); else npass++;
        ncheck++; if ({first_a, first_b, first_sum} !== 25'd0) $display("FAIL clr_first: got %h want 0", {first_a, first_b, first_sum}); else npass++;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_sum = 9'd19;
        @(posedge clk); #1;
        in_a = 8'd5; in_b = 8'd6; in_sum = 9'd12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // first beat has entered S2 and committed, second still waits in S1
        ncheck++; if (err_count !== 4'd1) $display("FAIL commit_point: got %0d want 1", err_count); else npass++;
        rst_n = 1'b0;
        #1;
        model_clear();
        ncheck++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %0b want 0", out_valid); else npass++;
        ncheck++; if ({err_sticky, err_count, first_a, first_b, first_sum} !== 30'd0) $display("FAIL rstmid_stats: got %h want 0", {err_sticky, err_count, first_a, first_b, first_sum}); else npass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd33; in_b = 8'd44; in_sum = 9'd77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ncheck++; if (out_valid !== 1'b0) $display("FAIL rstmid_early: got %0b want 0", out_valid); else npass++;
        @(posedge clk); #1;
        ncheck++; if ({out_valid, out_err, out_sum} !== {1'b1, 1'b0, 9'd77}) $display("FAIL rstmid_latency: got %h want %h", {out_valid, out_err, out_sum}, {1'b1, 1'b0, 9'd77}); else npass++;
        repeat (3) @(posedge clk); #1;
        ncheck++; if (exp_q.size() != 0) $display("FAIL rstmid_drain: got %0d pending want 0", exp_q.size()); else npass++;
    endtask

    initial begin
        test_reset();
        test_golden();
        test_fault();
        test_backpressure();
        test_random();
        test_saturation();
        test_clr_coincident();
        test_reset_midflight();
        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule

// File: doc/addr8u_result_checker.md
Name: addr8u_result_checker

Overview:
- Stage directly downstream of the 8-bit unsigned fault-resilient adder.
- Takes each operand pair A/B plus the adder's 9-bit output O[8:0] and recomputes the golden sum A+B.
- Forwards the result with a per-result error flag over a valid/ready handshake.
- Keeps run statistics for fault-injection campaigns: saturating mismatch count, sticky flag, and the first failing vector.

Parameters:
- WIDTH, 8, operand width; the sum is WIDTH+1 bits.
- CNT_W, 16, width of the mismatch counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  checker can accept a beat.
- in_a  input  WIDTH  operand A, the adder's A[7:0].
- in_b  input  WIDTH  operand B, the adder's B[7:0].
- in_sum  input  WIDTH+1  adder output O[8:0] for this A/B.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts a result.
- out_sum  output  WIDTH+1  registered copy of in_sum, passed through unmodified.
- out_err  output  1  1 when out_sum differs from A+B.
- clr_stats  input  1  synchronous clear of the statistics.
- err_count  output  CNT_W  saturating mismatch count.
- err_sticky  output  1  set on the first mismatch; held until clear or reset.
- first_a  output  WIDTH  A of the first mismatch.
- first_b  output  WIDTH  B of the first mismatch.
- first_sum  output  WIDTH+1  faulty sum of the first mismatch.

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids = 0, so out_valid=0; out_sum=0; out_err=0; err_count=0; err_sticky=0; first_a/b/sum=0. in_ready=1 as soon as reset deasserts.
- S1 capture stage:
  - Registers a, b and sum on in_valid && in_ready.
  - in_ready = !s1_v || !s2_v || out_ready.
  - No combinational path from in_valid to in_ready.
- S2 compare stage:
  - When S1 advances, S2 loads out_sum = s1_sum and out_err = (s1_sum != zero-extended s1_a + s1_b, full WIDTH+1-bit compare).
  - S1 advances when s1_v && (!s2_v || out_ready).
  - out_valid = s2_v.
- Throughput and latency:
  - Latency is 2 cycles from the input handshake to out_valid, when there is no backpressure.
  - Throughput is 1 beat/cycle when out_ready is held high.
- Backpressure:
  - out_sum and out_err stay stable while out_valid && !out_ready.
  - When both stages are full and out_ready=0, in_ready=0.
  - No beat is ever dropped or duplicated.
- Commit point: statistics update when an erroneous beat loads into S2, not when it leaves. Each beat is counted exactly once.
- err_count:
  - Increments by 1 per erroneous beat.
  - Saturates at 2^CNT_W-1 and holds.
- First-vector capture: on the first error while err_sticky=0, load first_a/first_b/first_sum and set err_sticky. Later errors do not alter the capture.
- clr_stats:
  - Zeroes err_count, err_sticky and first_*.
  - Has priority over a coincident error commit: that beat is not counted, but its out_err still reports 1.
  - Does not affect the pipeline contents or the handshake.
- Reset mid-operation: in-flight beats are discarded and all outputs return to their reset values immediately.
- Simultaneous S1 load and S2 drain in the same cycle is legal and required for full throughput.

Test Plan:
- Golden beat: a=200, b=100, sum=9'h12C, out_ready=1 → 2 cycles later out_valid=1, out_sum=12C, out_err=0, err_count=0.
- Faulty beat: a=200, b=100, sum=9'h12D → out_err=1, err_count=1, err_sticky=1, first_a=200, first_b=100, first_sum=12D.
  - A second fault with a=1, b=1, sum=3 → err_count=2, first_* unchanged.
- Backpressure: stream 5 beats with out_ready=0 → in_ready falls after 2 accepted beats, out_sum stays stable.
  - Then release out_ready → all 5 beats emerge in order with no loss or duplication.
- Saturation (CNT_W=4): 20 faulty beats → err_count stops at 15.
- clr_stats asserted in the same cycle a faulty beat commits → err_count=0 and err_sticky=0 afterwards; that beat's out_err=1 is still delivered.
- rst_n pulsed low with 2 beats in flight → out_valid=0 and all statistics=0 immediately.
  - The first beat after release appears 2 cycles after its handshake.
